// File: rtl/commit_monitor.sv
// commit_monitor
//   Watches the commit stage of a core. It counts cycles, committed
//   instructions, control-flow commits and mispredicts from the first commit
//   onward. It records the last committed PC and detects halt or hang.
//
//   Optional feature macro: COMMIT_MON_PC_HIST_EN
//     When defined, the last HIST_DEPTH counted PCs are kept in a circular
//     buffer. They are read combinationally through i_hist_idx / o_hist_pc.
//
//   Ports
//     i_clk          single clock, rising edge
//     i_reset        synchronous active-low reset
//     i_insn_vld     commit valid this cycle
//     i_ctrl         committing instruction is control flow (qualified by vld)
//     i_mispred      committing instruction was mispredicted (qualified by vld)
//     i_halt         core halt request (ignored in IDLE)
//     i_pc_commit    PC of the committing instruction
//     i_clear        synchronous soft clear back to IDLE
//     i_hist_idx     history read index, 0 = newest   (macro only)
//     o_hist_pc      history entry at i_hist_idx      (macro only)
//     o_state        IDLE=0, RUN=1, HALTED=2, HUNG=3
//     o_cycle_cnt / o_insn_cnt / o_ctrl_cnt / o_mispred_cnt  saturating counters
//     o_last_pc      PC of the most recent counted commit
//     o_done         high in HALTED
//     o_hung         high in HUNG
module commit_monitor #(
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 1024,
  parameter int HIST_DEPTH  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_insn_vld,
  input  logic             i_ctrl,
  input  logic             i_mispred,
  input  logic             i_halt,
  input  logic [31:0]      i_pc_commit,
  input  logic             i_clear,
`ifdef COMMIT_MON_PC_HIST_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_idx,
  output logic [31:0]      o_hist_pc,
`endif
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_insn_cnt,
  output logic [CNT_W-1:0] o_ctrl_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt,
  output logic [31:0]      o_last_pc,
  output logic             o_done,
  output logic             o_hung
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_HUNG   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_LIMIT);

  // Reject history depths the circular pointer cannot wrap correctly.
  if (HIST_DEPTH < 2 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_hist_depth
    $error("commit_monitor: HIST_DEPTH must be a power of two >= 2");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cycle_r, cycle_n;
  logic [CNT_W-1:0] insn_r, insn_n;
  logic [CNT_W-1:0] ctrl_r, ctrl_n;
  logic [CNT_W-1:0] mispred_r, mispred_n;
  logic [CNT_W-1:0] stall_r, stall_n;
  logic [31:0]      last_pc_r, last_pc_n;
  logic             done_r, hung_r;
  logic             count_s;

  // Next-state and counter update; HALTED/HUNG hold everything.
  always_comb begin
    state_n   = state_r;
    cycle_n   = cycle_r;
    stall_n   = stall_r;
    count_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_insn_vld) begin
          state_n = ST_RUN;
          cycle_n = CNT_ONE;
          count_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        cycle_n = sat_inc(cycle_r);
        if (i_insn_vld) begin
          count_s = 1'b1;
          stall_n = '0;
        end else begin
          stall_n = sat_inc(stall_r);
        end
        // Halt wins over a hang detected in the same cycle.
        if (i_halt) begin
          state_n = ST_HALTED;
        end else if (!i_insn_vld && sat_inc(stall_r) == STALL_LIM) begin
          state_n = ST_HUNG;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_HALTED, ST_HUNG: begin
        state_n = state_r;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (count_s) begin
      insn_n    = sat_inc(insn_r);
      ctrl_n    = i_ctrl    ? sat_inc(ctrl_r)    : ctrl_r;
      mispred_n = i_mispred ? sat_inc(mispred_r) : mispred_r;
      last_pc_n = i_pc_commit;
    end else begin
      insn_n    = insn_r;
      ctrl_n    = ctrl_r;
      mispred_n = mispred_r;
      last_pc_n = last_pc_r;
    end
  end

  // State and counter registers; reset overrides clear, clear overrides update.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      state_r   <= ST_IDLE;
      cycle_r   <= '0;
      insn_r    <= '0;
      ctrl_r    <= '0;
      mispred_r <= '0;
      stall_r   <= '0;
      last_pc_r <= 32'h0000_0000;
      done_r    <= 1'b0;
      hung_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cycle_r   <= cycle_n;
      insn_r    <= insn_n;
      ctrl_r    <= ctrl_n;
      mispred_r <= mispred_n;
      stall_r   <= stall_n;
      last_pc_r <= last_pc_n;
      done_r    <= (state_n == ST_HALTED);
      hung_r    <= (state_n == ST_HUNG);
    end
  end

  assign o_state       = state_r;
  assign o_cycle_cnt   = cycle_r;
  assign o_insn_cnt    = insn_r;
  assign o_ctrl_cnt    = ctrl_r;
  assign o_mispred_cnt = mispred_r;
  assign o_last_pc     = last_pc_r;
  assign o_done        = done_r;
  assign o_hung        = hung_r;

`ifdef COMMIT_MON_PC_HIST_EN
  localparam int HIST_AW = $clog2(HIST_DEPTH);

  logic [31:0]        hist_r [HIST_DEPTH];
  logic [HIST_AW-1:0] wptr_r;
  logic [HIST_AW-1:0] rd_idx_s;

  // History buffer: written only by counted commits, so it freezes on its own
  // in HALTED/HUNG; the pointer wraps naturally at the power-of-two depth.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_r[i] <= 32'h0000_0000;
      end
      wptr_r <= '0;
    end else if (count_s) begin
      hist_r[wptr_r] <= i_pc_commit;
      wptr_r         <= wptr_r + HIST_AW'(1'b1);
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // Newest entry sits one slot behind the write pointer.
  always_comb begin
    rd_idx_s  = wptr_r - HIST_AW'(1'b1) - i_hist_idx;
    o_hist_pc = hist_r[rd_idx_s];
  end
`endif

endmodule

// File: tb/tb_commit_monitor.sv
module tb_commit_monitor;
  localparam int CNT_W       = 4;
  localparam int STALL_LIMIT = 4;
  localparam int HIST_DEPTH  = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, vld, ctrl, mis, halt, clr;
  logic [31:0]      pc;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_cycle, o_insn, o_ctrl, o_mis;
  logic [31:0]      o_last;
  logic             o_done, o_hung;
`ifdef COMMIT_MON_PC_HIST_EN
  logic [1:0]       hidx;
  logic [31:0]      hist_pc;
`endif

  commit_monitor #(.CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT), .HIST_DEPTH(HIST_DEPTH)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_insn_vld(vld), .i_ctrl(ctrl), .i_mispred(mis),
    .i_halt(halt), .i_pc_commit(pc), .i_clear(clr),
`ifdef COMMIT_MON_PC_HIST_EN
    .i_hist_idx(hidx), .o_hist_pc(hist_pc),
`endif
    .o_state(o_state), .o_cycle_cnt(o_cycle), .o_insn_cnt(o_insn), .o_ctrl_cnt(o_ctrl),
    .o_mispred_cnt(o_mis), .o_last_pc(o_last), .o_done(o_done), .o_hung(o_hung)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers and a newest-first PC queue.
  int          m_state, m_cycle, m_insn, m_ctrl, m_mis, m_stall;
  logic [31:0] m_last;
  logic [31:0] m_hist[$];

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_zero();
    m_state = 0; m_cycle = 0; m_insn = 0; m_ctrl = 0; m_mis = 0; m_stall = 0;
    m_last = 32'h0;
    m_hist = {};
    repeat (HIST_DEPTH) m_hist.push_back(32'h0);
  endtask

  task automatic model_edge();
    bit counted = 1'b0;
    if (!rst_n || clr) begin
      model_zero();
    end else if (m_state == 0) begin
      if (vld) begin
        m_state = 1; m_cycle = 1; counted = 1'b1;
      end
    end else if (m_state == 1) begin
      m_cycle = sat(m_cycle + 1);
      if (vld) begin
        counted = 1'b1; m_stall = 0;
      end else begin
        m_stall++;
      end
      if (halt) m_state = 2;
      else if (m_stall >= STALL_LIMIT) m_state = 3;
    end
    if (counted) begin
      m_insn = sat(m_insn + 1);
      if (ctrl) m_ctrl = sat(m_ctrl + 1);
      if (mis)  m_mis  = sat(m_mis + 1);
      m_last = pc;
      m_hist.push_front(pc);
      void'(m_hist.pop_back());
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",   32'(o_state), 32'(m_state));
    check("cycle",   32'(o_cycle), 32'(m_cycle));
    check("insn",    32'(o_insn),  32'(m_insn));
    check("ctrl",    32'(o_ctrl),  32'(m_ctrl));
    check("mispred", 32'(o_mis),   32'(m_mis));
    check("last_pc", o_last,       m_last);
    check("done",    32'(o_done),  32'(m_state == 2));
    check("hung",    32'(o_hung),  32'(m_state == 3));
`ifdef COMMIT_MON_PC_HIST_EN
    for (int i = 0; i < HIST_DEPTH; i++) begin
      hidx = 2'(i);
      #1;
      check("hist", hist_pc, m_hist[i]);
    end
`endif
  endtask

  task automatic step(input bit v, input bit c, input bit m, input bit h,
                      input bit cl, input bit r, input logic [31:0] p);
    vld = v; ctrl = c; mis = m; halt = h; clr = cl; rst_n = r; pc = p;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic commit(input logic [31:0] p);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, p);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
  endtask

  initial begin
    int dens;
    vld = 1'b0; ctrl = 1'b0; mis = 1'b0; halt = 1'b0; clr = 1'b0; rst_n = 1'b0;
    pc = 32'h0;
`ifdef COMMIT_MON_PC_HIST_EN
    hidx = 2'd0;
`endif
    model_zero();

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_state", 32'(o_state), 32'd0);
    check("reset_insn",  32'(o_insn),  32'd0);

    // Three commits, second is ctrl+mispred
    commit(32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
    commit(32'h8);
    check("basic_state",   32'(o_state), 32'd1);
    check("basic_insn",    32'(o_insn),  32'd3);
    check("basic_ctrl",    32'(o_ctrl),  32'd1);
    check("basic_mispred", 32'(o_mis),   32'd1);
    check("basic_last",    o_last,       32'h8);
    check("basic_cycle",   32'(o_cycle), 32'd3);

    // Hang after STALL_LIMIT idle cycles; later commit ignored
    clear();
    commit(32'h100);
    idle(); idle(); idle();
    check("hang_early", 32'(o_hung), 32'd0);
    idle();
    check("hang_hit", 32'(o_hung), 32'd1);
    commit(32'h104);
    check("hang_frozen_insn", 32'(o_insn), 32'd1);

    // Halt with a commit in the same cycle, then clear
    clear();
    commit(32'h30);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    check("halt_done", 32'(o_done), 32'd1);
    check("halt_insn", 32'(o_insn), 32'd2);
    check("halt_last", o_last, 32'h40);
    commit(32'h44); commit(32'h48);
    check("halt_frozen", 32'(o_insn), 32'd2);
    clear();
    check("clear_state", 32'(o_state), 32'd0);
    check("clear_cycle", 32'(o_cycle), 32'd0);

    // Halt ignored in IDLE
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    check("idle_halt", 32'(o_state), 32'd0);

    // Saturation
    clear();
    repeat (20) commit(32'h200);
    check("sat_insn",  32'(o_insn),  32'd15);
    check("sat_cycle", 32'(o_cycle), 32'd15);
    idle(); idle();
    check("sat_hold", 32'(o_cycle), 32'd15);

    // Reset in HUNG together with clear and a commit
    clear();
    commit(32'h300);
    repeat (STALL_LIMIT) idle();
    check("pre_reset_hung", 32'(o_hung), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h304);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_insn",  32'(o_insn),  32'd0);

`ifdef COMMIT_MON_PC_HIST_EN
    // History ordering
    clear();
    for (int i = 0; i < 5; i++) commit(32'h10 + 32'(4 * i));
    hidx = 2'd0; #1;
    check("hist_idx0", hist_pc, 32'h20);
    hidx = 2'd3; #1;
    check("hist_idx3", hist_pc, 32'h14);
`endif

    // Randomised phase with varying commit density
    dens = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) dens = (n % 600 == 0) ? 90 : ((n % 600 == 200) ? 60 : 30);
      step(($urandom_range(0, 99) < dens), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 149) != 0), $urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_monitor.md
COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 Parameters SHALL be, as name, default, meaning: CNT_W, 32, width of every event counter.
REQ-002 STALL_LIMIT, 1024, consecutive no-commit cycles in RUN that declare a hang (range 2..2^CNT_W-1).
REQ-003 HIST_DEPTH, 8, PC history entries (power of two, at least 2; used only under REQ-026).
REQ-004 Ports SHALL be, as name, direction, width, meaning: i_clk, in, 1, single clock, all logic on rising edge.
REQ-005 i_reset, in, 1, synchronous active-low reset.
REQ-006 i_insn_vld / i_ctrl / i_mispred / i_halt, in, 1 each, commit-stage status from the core.
REQ-007 i_pc_commit, in, 32, PC of the committing instruction.
REQ-008 i_clear, in, 1, synchronous soft clear.
REQ-009 o_state, out, 2, state encoding: IDLE=0, RUN=1, HALTED=2, HUNG=3.
REQ-010 o_cycle_cnt / o_insn_cnt / o_ctrl_cnt / o_mispred_cnt, out, CNT_W each, event counters.
REQ-011 o_last_pc, out, 32, PC of the most recent counted commit.
REQ-012 o_done, out, 1, high in HALTED; o_hung, out, 1, high in HUNG.

Function
REQ-013 A "commit" SHALL be any cycle with i_insn_vld=1; i_ctrl and i_mispred SHALL be ignored when i_insn_vld=0.
REQ-014 IDLE->RUN SHALL occur on the first commit; that commit SHALL be counted, and o_cycle_cnt SHALL be set to 1 in the same edge.
REQ-015 In RUN, o_cycle_cnt SHALL increment by 1 every cycle, including the HALTED/HUNG transition cycle.
REQ-016 In IDLE/RUN, each commit SHALL increment o_insn_cnt; also o_ctrl_cnt if i_ctrl=1; also o_mispred_cnt if i_mispred=1.
REQ-017 Each counted commit SHALL load o_last_pc with i_pc_commit.
REQ-018 All counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-019 An internal stall counter SHALL clear on every commit and increment on every RUN cycle without one; RUN->HUNG SHALL occur on the edge where it reaches STALL_LIMIT.
REQ-020 RUN->HALTED SHALL occur on the edge with i_halt=1; a commit in that same cycle SHALL be counted; halt SHALL take priority over the hang condition.
REQ-021 i_halt SHALL be ignored in IDLE.
REQ-022 HALTED and HUNG SHALL be sticky: counters and o_last_pc frozen, all inputs except i_clear ignored.
REQ-023 i_clear=1 SHALL, in any state, return to IDLE and zero all counters, o_last_pc and the stall counter; a commit in the clear cycle SHALL NOT be counted.
REQ-024 All outputs SHALL be registered, updating one edge after the causing input.

Reset
REQ-025 When i_reset=0 at a rising edge: o_state=IDLE, all counters 0, o_last_pc=0, o_done=0, o_hung=0, stall counter 0, history write pointer 0. Reset SHALL override i_clear and take effect mid-operation in any state.

Configuration
REQ-026 With COMMIT_MON_PC_HIST_EN defined:
- extra ports i_hist_idx (in, log2(HIST_DEPTH)) and o_hist_pc (out, 32) SHALL exist;
- each counted commit SHALL write its PC into a circular buffer at the write pointer, which then advances modulo HIST_DEPTH;
- o_hist_pc SHALL be combinational and return the entry i_hist_idx positions back from the newest (0=newest);
- entries SHALL be 0 after reset or clear, and the buffer SHALL freeze in HALTED/HUNG.
REQ-027 Without the macro, these ports and this storage SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset, then three commits at PCs 0x0, 0x4, 0x8 with the second having ctrl=1 and mispred=1 -> o_state=RUN, insn=3, ctrl=1, mispred=1, o_last_pc=0x8, cycle=3.
REQ-029 With STALL_LIMIT=4, one commit followed by no commits -> o_hung=1 on the 4th edge after the commit; a later commit leaves insn=1.
REQ-030 Commit with i_halt=1 at PC 0x40 -> o_done=1, insn includes it, o_last_pc=0x40; further commits change nothing; i_clear -> IDLE with all counters 0.
REQ-031 CNT_W=4 with 20 consecutive commits -> o_insn_cnt=15 and o_cycle_cnt=15, both held.
REQ-032 i_reset=0 asserted in HUNG concurrently with i_clear and a commit -> next edge IDLE, all counters 0.
REQ-033 With COMMIT_MON_PC_HIST_EN and HIST_DEPTH=4, commits at PCs 0x10, 0x14, 0x18, 0x1C, 0x20 -> idx0=0x20, idx3=0x14.
